// File: rtl/nor_wb_bus_ctrl_if.sv
// nor_wb_bus_ctrl_if: pipelined Wishbone request/response bundle between the QSPI FSM and the NOR bus controller
interface nor_wb_bus_ctrl_if #(
  parameter int ADDRBITS = 26,
  parameter int DATABITS = 16
);
  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic                wb_we_i;
  logic [ADDRBITS-1:0] wb_adr_i;
  logic [DATABITS-1:0] wb_dat_i;
  logic [DATABITS-1:0] wb_dat_o;
  logic                wb_ack_o;
  logic                wb_err_o;
  logic                wb_stall_o;
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );
endinterface

// File: rtl/nor_wb_bus_ctrl.sv
// nor_wb_bus_ctrl: Wishbone slave running timed single-word read/write cycles on a parallel NOR flash bus.
// Define NOR_RDY_WAIT_EN to wait on ready/busy# (with timeout) after every write.
module nor_wb_bus_ctrl #(
  parameter int          ADDRBITS = 26,
  parameter int          DATABITS = 16,
  parameter int          T_RD     = 7,
  parameter int          T_WS     = 2,
  parameter int          T_WP     = 4,
  parameter int          T_WH     = 2,
  parameter logic [15:0] T_TO     = 16'hFFFF
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  nor_wb_bus_ctrl_if.slave      wb,
  output logic [ADDRBITS-1:0]   nor_a_o,
  output logic [DATABITS-1:0]   nor_dq_o,
  input  logic [DATABITS-1:0]   nor_dq_i,
  output logic                  nor_dq_oe_o,
  output logic                  nor_ce_n_o,
  output logic                  nor_oe_n_o,
  output logic                  nor_we_n_o,
  input  logic                  nor_ry_by_n_i
);
  localparam logic [7:0] RD_N = 8'(T_RD - 1);
  localparam logic [7:0] WS_N = 8'(T_WS - 1);
  localparam logic [7:0] WP_N = 8'(T_WP - 1);
  localparam logic [7:0] WH_N = 8'(T_WH - 1);
  typedef enum logic [2:0] {
    IDLE, RD, WS, WP, WH, TURN
`ifdef NOR_RDY_WAIT_EN
    , RDY
`endif
  } state_t;
  state_t              state_q;
  logic [7:0]          cnt_q;
  logic [ADDRBITS-1:0] a_q;
  logic [DATABITS-1:0] dq_q, dat_q;
  logic                ce_n_q, oe_n_q, we_n_q, dq_oe_q;
  logic                ack_q, err_q, stall_q, abort_q;
  logic                ok;
  // a dropped cycle lets the flash access finish but silences its response
  assign ok = wb.wb_cyc_i & ~abort_q;
`ifdef NOR_RDY_WAIT_EN
  logic        ry_s1_q, ry_s2_q;
  logic [15:0] to_q;
`else
  logic unused_ry;
  assign unused_ry = nor_ry_by_n_i;
`endif
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      dq_q    <= '0;
      dat_q   <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      abort_q <= 1'b0;
`ifdef NOR_RDY_WAIT_EN
      ry_s1_q <= 1'b0;
      ry_s2_q <= 1'b0;
      to_q    <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
`ifdef NOR_RDY_WAIT_EN
      ry_s1_q <= nor_ry_by_n_i;
      ry_s2_q <= ry_s1_q;
`endif
      if (state_q != IDLE && !wb.wb_cyc_i) abort_q <= 1'b1;
      case (state_q)
        IDLE: if (wb.wb_cyc_i && wb.wb_stb_i) begin
          a_q     <= wb.wb_adr_i;
          dq_q    <= wb.wb_dat_i;
          abort_q <= 1'b0;
          stall_q <= 1'b1;
          ce_n_q  <= 1'b0;
          oe_n_q  <= wb.wb_we_i;
          dq_oe_q <= wb.wb_we_i;
          state_q <= wb.wb_we_i ? WS : RD;
          cnt_q   <= wb.wb_we_i ? WS_N : RD_N;
        end
        RD: if (cnt_q == 8'd0) begin
          dat_q   <= nor_dq_i;
          ack_q   <= ok;
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          state_q <= TURN;
        end else cnt_q <= cnt_q - 8'd1;
        WS: if (cnt_q == 8'd0) begin
          we_n_q  <= 1'b0;
          cnt_q   <= WP_N;
          state_q <= WP;
        end else cnt_q <= cnt_q - 8'd1;
        WP: if (cnt_q == 8'd0) begin
          we_n_q  <= 1'b1;
          cnt_q   <= WH_N;
          state_q <= WH;
        end else cnt_q <= cnt_q - 8'd1;
        WH: if (cnt_q == 8'd0) begin
          ce_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
`ifdef NOR_RDY_WAIT_EN
          to_q    <= '0;
          state_q <= RDY;
`else
          ack_q   <= ok;
          state_q <= TURN;
`endif
        end else cnt_q <= cnt_q - 8'd1;
`ifdef NOR_RDY_WAIT_EN
        RDY: if (ry_s2_q) begin
          ack_q   <= ok;
          state_q <= TURN;
        end else if (to_q == T_TO - 16'd1) begin
          err_q   <= ok;
          state_q <= TURN;
        end else to_q <= to_q + 16'd1;
`endif
        TURN: begin
          stall_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign wb.wb_dat_o   = dat_q;
  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_err_o   = err_q;
  assign wb.wb_stall_o = stall_q;
  assign nor_a_o       = a_q;
  assign nor_dq_o      = dq_q;
  assign nor_dq_oe_o   = dq_oe_q;
  assign nor_ce_n_o    = ce_n_q;
  assign nor_oe_n_o    = oe_n_q;
  assign nor_we_n_o    = we_n_q;
endmodule
